// File: rtl/mulu_if.sv
// Operand/result bundle for the mulu shift-add multiplier.
// The master drives the operands and start; the slave returns status and the product.
interface mulu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output a, b, start, input  busy, done, hi, lo);
  modport slave  (input  a, b, start, output busy, done, hi, lo);
endinterface

// File: rtl/mulu.sv
// 32x32 unsigned radix-2 shift-add multiplier: 32 iterations per product, with a registered {hi,lo} result.
// A start request always restarts the operation, even one that is already running.
module mulu (
  input  logic   clock,
  input  logic   reset,
  mulu_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [63:0] p_q, p_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] sum;
  logic [63:0] p_step;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The 33-bit sum keeps the carry, and the right shift moves that carry into bit 63.
  always_comb begin
    sum    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
    p_step = {sum, p_q[31:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // A start request overrides both a running iteration and a pending completion.
    if (bus.start) begin
      state_d = S_BUSY;
      cnt_d   = '0;
      a_d     = bus.a;
      p_d     = {32'd0, bus.b};
    end else if (state_q == S_BUSY) begin
      p_d = p_step;
      if (cnt_q == 5'd31) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        hi_d    = p_step[63:32];
        lo_d    = p_step[31:0];
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  assign bus.busy = (state_q == S_BUSY);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mulu.sv
// Self-checking bench for mulu: directed scenarios, then random operands and start/reset traffic.
// Each clock edge is compared against a cycle-level model that uses native 64-bit multiplication.
module tb_mulu;

  logic clock;
  logic reset;

  mulu_if bus ();

  mulu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: the expected outputs and the number of edges left in the current operation.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_prod = '0;
  int          m_rem  = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Apply one rising edge, advance the model with the inputs sampled at that edge,
  // then compare all outputs just after the edge.
  task automatic tick(input string tag);
    @(posedge clock);
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      m_rem  = 0;
    end else if (bus.start) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_prod = 64'(bus.a) * 64'(bus.b);
      m_rem  = 32;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_prod;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
    check({tag, ".busy"}, 64'(bus.busy), 64'(m_busy));
    check({tag, ".done"}, 64'(bus.done), 64'(m_done));
    check({tag, ".hilo"}, {bus.hi, bus.lo}, m_res);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick(tag);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 32'd11;
    bus.b     = 32'd13;

    // Reset held for two edges while start is also requested.
    run(2, "reset");
    check("reset.busy_const", 64'(bus.busy), 64'd0);
    check("reset.hilo_const", {bus.hi, bus.lo}, 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    run(2, "idle");

    // Basic multiply: 7*6.
    start_op(32'd7, 32'd6, "basic.E");
    run(31, "basic.run");
    tick("basic.E32");
    check("basic.done_const", 64'(bus.done), 64'd1);
    check("basic.lo_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
    tick("basic.E33");
    check("basic.done_clr", 64'(bus.done), 64'd0);

    // Maximum operands, started in the cycle after the previous done.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max.E");
    run(31, "max.run");
    tick("max.E32");
    check("max.result", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // A zero operand still takes the full 32 cycles.
    start_op(32'd0, 32'h1234_5678, "zero.E");
    run(31, "zero.run");
    tick("zero.E32");
    check("zero.done", 64'(bus.done), 64'd1);
    check("zero.result", {bus.hi, bus.lo}, 64'd0);
    run(3, "zero.idle");

    // Restart mid-operation at E+10.
    start_op(32'd3, 32'd5, "restart.E");
    run(9, "restart.run1");
    start_op(32'h0001_0000, 32'h0001_0000, "restart.E10");
    run(31, "restart.run2");
    tick("restart.E42");
    check("restart.result", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    run(2, "restart.idle");

    // Reset mid-operation at E+5, followed by a clean operation.
    start_op(32'd9, 32'd9, "rstmid.E");
    run(4, "rstmid.run");
    reset = 1'b1;
    tick("rstmid.E5");
    reset = 1'b0;
    run(40, "rstmid.after");
    start_op(32'd2, 32'd3, "rstmid.new");
    run(32, "rstmid.new_run");
    check("rstmid.result", {bus.hi, bus.lo}, 64'd6);

    // Start held high for 40 edges: the operation keeps restarting and never completes.
    bus.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      tick("hold");
    end
    bus.start = 1'b0;
    run(33, "hold.release");

    // Random traffic: sparse starts, back-to-back starts after done, rare resets, corner operands.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r         = $urandom_range(0, 99);
      bus.start = (r < 3) || (bus.done && r < 50);
      reset     = ($urandom_range(0, 399) == 0);
      case ($urandom_range(0, 7))
        0: bus.a = '0;
        1: bus.a = '1;
        default: bus.a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: bus.b = '0;
        1: bus.b = '1;
        default: bus.b = $urandom;
      endcase
      tick("rand");
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    run(34, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mulu.md
MULU -- requirements
Module: mulu

Interface
REQ-001: clock  input  1  single clock for all state; every register updates on the rising edge.
REQ-002: reset  input  1  reset is synchronous and active-high.
REQ-003: a  input  32  unsigned multiplicand, sampled only at the edge where start is accepted.
REQ-004: b  input  32  unsigned multiplier, sampled only at the edge where start is accepted.
REQ-005: start  input  1  request to begin a multiply, sampled every edge.
REQ-006: busy  output  1  high while an operation is in progress.
REQ-007: done  output  1  one-cycle pulse marking a completed operation.
REQ-008: hi  output  32  upper 32 bits of the 64-bit product, registered.
REQ-009: lo  output  32  lower 32 bits of the 64-bit product, registered.

Function
REQ-010: mulu SHALL compute the unsigned 64-bit product {hi,lo} = a*b with no overflow or truncation.
REQ-011: The algorithm SHALL be radix-2 shift-add, one multiplier bit per cycle.
- Working register P holds 64 bits plus one carry bit.
- On accept: P[63:32]=0, P[31:0]=b.
- Each iteration: if P[0] is set, add a to P[63:32] as a 33-bit sum; then shift {sum,P[31:1]} right by one.
REQ-012: An internal 5-bit counter SHALL count iterations 0..31 and SHALL NOT wrap into a 33rd iteration.
REQ-013: Accept timing SHALL be as follows.
- At edge E where start=1 and reset=0, a and b are latched, P is initialised and the counter is cleared.
- busy reads 1 after edge E.
REQ-014: Edges E+1 through E+32 SHALL each perform exactly one iteration, giving exactly 32 cycles regardless of operand values (zero operands included).
REQ-015: At edge E+32, with no intervening start or reset, busy SHALL be set to 0, done to 1, and {hi,lo} loaded with the final P.
REQ-016: done SHALL return to 0 at edge E+33 and SHALL never be high for more than one cycle per operation.
REQ-017: hi and lo SHALL change only at a completion edge or on reset, and SHALL hold the last result indefinitely while idle or during a new operation.
REQ-018: Start while busy SHALL abort the current operation and restart with the newly sampled a, b.
- The aborted operation produces no done pulse and no hi/lo update.
REQ-019: Start at the completion edge SHALL take priority over completion.
- The old result is discarded and the new operation begins.
- busy stays 1, done stays 0, hi/lo are unchanged.
REQ-020: start held high continuously SHALL restart every cycle, so the operation never completes and done never asserts.
REQ-021: The state machine SHALL have two states.
- IDLE to BUSY on start.
- BUSY to BUSY on start (restart) or while count<31.
- BUSY to IDLE on the 32nd iteration edge.
- IDLE with start=0 stays IDLE.
REQ-022: The start-to-done latency SHALL be 32 cycles, and back-to-back operations SHALL be possible by asserting start in the cycle after done.

Reset
REQ-023: When reset=1 at an edge, the block SHALL set busy=0, done=0, hi=0, lo=0, the counter to 0 and P to 0.
REQ-024: Reset SHALL take priority over start and over any in-progress operation.
- A multiply interrupted by reset produces no done and no result.
REQ-025: After reset deasserts, the block SHALL be idle and SHALL accept start on the first edge with reset=0.

Verification
REQ-026: Reset test: hold reset for 2 cycles with start=1 -> busy=0, done=0, hi=0, lo=0; no operation begins.
REQ-027: Basic multiply: a=7, b=6, start at edge E.
- busy=1 over E+1..E+31.
- At E+32: busy=0, done=1, hi=0x00000000, lo=0x0000002A.
- At E+33: done=0 and the result is held.
REQ-028: Maximum operands: a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after exactly 32 cycles.
REQ-029: Zero operand: a=0, b=0x12345678 -> hi=0, lo=0, with done still exactly at E+32.
REQ-030: Restart mid-operation: start a=3, b=5 at E, then start a=0x00010000, b=0x00010000 at E+10.
- No done at E+32.
- done at E+42 with hi=0x00000001, lo=0x00000000.
- hi/lo keep their previous values until E+42.
REQ-031: Reset mid-operation: start a=9, b=9 at E, reset at E+5.
- busy=0, hi=lo=0, and done never asserts.
- A subsequent start a=2, b=3 yields lo=6 after 32 cycles.
